// File: rtl/btm_acc.sv
// Purpose: sums a frame of signed btm products (NACC beats, or fewer when i_last ends it early) into one dot-product result.
// Latency: o_valid rises 1 cycle after the final beat is accepted; there is one input bubble per frame.
// Backpressure: o_ready stays low while a result waits; the result holds until o_valid & i_ready.
// Build option: define BTM_ACC_SAT_EN to clip on overflow; left undefined, the sum wraps modulo 2^DACC.
module btm_acc #(
   parameter int DI   = 19,
   parameter int NACC = 8,
   parameter int CW   = 4,
   parameter int DACC = 22
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [DI-1:0]   i_din,
   input  logic            i_valid,
   input  logic            i_last,
   output logic            o_ready,
   output logic [DACC-1:0] o_dout,
   output logic            o_valid,
   input  logic            i_ready,
   output logic            o_ovf
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   localparam logic [DACC-1:0] SUM_MAX = {1'b0, {(DACC-1){1'b1}}};
   localparam logic [DACC-1:0] SUM_MIN = {1'b1, {(DACC-1){1'b0}}};

   logic [1:0]      state;
   logic [DACC-1:0] acc;
   logic [CW-1:0]   cnt;

   logic [DACC-1:0] din_ext;
   logic [DACC-1:0] base;
   logic [DACC-1:0] sum;
   logic [DACC-1:0] nxt;
   logic            add_ovf;
   logic            accept;
   logic            xfer;
   logic            final_beat;

   assign accept     = i_valid & o_ready;
   assign xfer       = o_valid & i_ready;
   assign final_beat = i_last | (cnt == CW'(NACC - 1));
   assign din_ext    = DACC'($signed(i_din));

   // The first beat of a frame starts from zero, so stale accumulator contents cannot leak into a new frame.
   always_comb begin
      base    = (cnt == '0) ? '0 : acc;
      sum     = base + din_ext;
      add_ovf = (base[DACC-1] == din_ext[DACC-1]) && (sum[DACC-1] != base[DACC-1]);
`ifdef BTM_ACC_SAT_EN
      if (add_ovf) begin
         nxt = base[DACC-1] ? SUM_MIN : SUM_MAX;
      end else begin
         nxt = sum;
      end
`else
      nxt = sum;
`endif
   end

   // Frame FSM, the registered output handshake and the sticky overflow flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= S_IDLE;
         acc     <= '0;
         cnt     <= '0;
         o_dout  <= '0;
         o_valid <= 1'b0;
         o_ready <= 1'b1;
         o_ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_ACC: begin
               if (accept) begin
                  if (final_beat) begin
                     o_dout  <= nxt;
                     o_valid <= 1'b1;
                     o_ready <= 1'b0;
                     acc     <= '0;
                     cnt     <= '0;
                     state   <= S_FULL;
                  end else begin
                     acc   <= nxt;
                     cnt   <= cnt + CW'(1);
                     state <= S_ACC;
                  end
               end
            end
            S_FULL: begin
               if (xfer) begin
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  acc     <= '0;
                  cnt     <= '0;
                  state   <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
         if (accept && add_ovf) begin
            o_ovf <= 1'b1;
         end
      end
   end

endmodule
